// File: rtl/regfile_fwd_pkg.sv
// Shared definitions for the OpenMIPS register file slice.
//   RegBus / RegAddrBus     : data and register-address widths
//   ZeroWord / NOPRegAddr   : all-zero data word and the hardwired-zero register
//   WriteEnable/Disable     : polarity of write enables
//   ReadEnable/Disable      : polarity of read enables
//   RstEnable               : level of rst that means "in reset" (active-low)
package regfile_fwd_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  localparam logic RstEnable    = 1'b0;

endpackage

// File: rtl/regfile_fwd_if.sv
// Bus between the pipeline (ID/EX/MEM/WB) and the register file.
//   master : pipeline side, drives WB write port, read requests and the
//            EX/MEM result triples; receives operands, stall and debug count
//   slave  : register file side
interface regfile_fwd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;

  logic              ex_wreg;
  logic [ADDR_W-1:0] ex_wd;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_is_load;

  logic              mem_wreg;
  logic [ADDR_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              stallreq;
  logic [15:0]       wr_cnt;

  modport master (
    output we, waddr, wdata,
    output re1, raddr1, re2, raddr2,
    output ex_wreg, ex_wd, ex_wdata, ex_is_load,
    output mem_wreg, mem_wd, mem_wdata,
    input  rdata1, rdata2, stallreq, wr_cnt
  );

  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1, re2, raddr2,
    input  ex_wreg, ex_wd, ex_wdata, ex_is_load,
    input  mem_wreg, mem_wd, mem_wdata,
    output rdata1, rdata2, stallreq, wr_cnt
  );

endinterface

// File: rtl/regfile_fwd_fwd_mux.sv
// Per-read-port operand selector.
//   addr/en            : read address and enable of this port
//   ex_* / mem_* / wb_*: in-flight results, youngest (EX) first
//   arr_data           : architectural value read from the array
//   data               : selected operand
module regfile_fwd_fwd_mux
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] data
);

  // r0 is checked before any forwarding source so a stray result aimed at
  // r0 can never leak into an operand.
  always_comb begin
    data = arr_data;
    if (en == ReadDisable || addr == ADDR_W'(NOPRegAddr)) begin
      data = DATA_W'(ZeroWord);
    end else if (ex_wreg == WriteEnable && ex_wd == addr) begin
      data = ex_wdata;
    end else if (mem_wreg == WriteEnable && mem_wd == addr) begin
      data = mem_wdata;
    end else if (wb_we == WriteEnable && wb_waddr == addr) begin
      data = wb_wdata;
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// General-purpose register file with EX/MEM/WB forwarding and load-use
// hazard detection, sitting between ID and write-back.
//   clk : core clock, rising edge
//   rst : asynchronous reset, active low
//   bus : regfile_fwd_if.slave -- WB write port, two read ports, EX/MEM
//         result triples, forwarded operands, stallreq and the saturating
//         count of committed writes (wr_cnt)
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  regfile_fwd_if.slave  bus
);

  logic [DATA_W-1:0] regs [NREG];
  logic [15:0]       wr_cnt_q;
  logic              wr_ok;
  logic [DATA_W-1:0] arr1;
  logic [DATA_W-1:0] arr2;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic              hazard;

  assign wr_ok = (bus.we != WriteDisable) && (bus.waddr != ADDR_W'(NOPRegAddr));

  // Storage and commit counter; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
      if (wr_cnt_q != 16'hFFFF) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign arr1 = regs[bus.raddr1];
  assign arr2 = regs[bus.raddr2];

  regfile_fwd_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux1 (
    .addr      (bus.raddr1),
    .en        (bus.re1),
    .ex_wreg   (bus.ex_wreg),
    .ex_wd     (bus.ex_wd),
    .ex_wdata  (bus.ex_wdata),
    .mem_wreg  (bus.mem_wreg),
    .mem_wd    (bus.mem_wd),
    .mem_wdata (bus.mem_wdata),
    .wb_we     (bus.we),
    .wb_waddr  (bus.waddr),
    .wb_wdata  (bus.wdata),
    .arr_data  (arr1),
    .data      (fwd1)
  );

  regfile_fwd_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux2 (
    .addr      (bus.raddr2),
    .en        (bus.re2),
    .ex_wreg   (bus.ex_wreg),
    .ex_wd     (bus.ex_wd),
    .ex_wdata  (bus.ex_wdata),
    .mem_wreg  (bus.mem_wreg),
    .mem_wd    (bus.mem_wd),
    .mem_wdata (bus.mem_wdata),
    .wb_we     (bus.we),
    .wb_waddr  (bus.waddr),
    .wb_wdata  (bus.wdata),
    .arr_data  (arr2),
    .data      (fwd2)
  );

  // A load in EX has no data yet; any enabled reader of its destination
  // must hold in ID. The forwarded (stale) value is still presented.
  always_comb begin
    hazard = 1'b0;
    if (bus.ex_is_load && bus.ex_wreg == WriteEnable &&
        bus.ex_wd != ADDR_W'(NOPRegAddr)) begin
      hazard = (bus.re1 == ReadEnable && bus.raddr1 == bus.ex_wd) ||
               (bus.re2 == ReadEnable && bus.raddr2 == bus.ex_wd);
    end
  end

  // Outputs are held quiet for the whole time reset is asserted.
  assign bus.rdata1   = (rst == RstEnable) ? '0   : fwd1;
  assign bus.rdata2   = (rst == RstEnable) ? '0   : fwd2;
  assign bus.stallreq = (rst == RstEnable) ? 1'b0 : hazard;
  assign bus.wr_cnt   = wr_cnt_q;

endmodule
